// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle instruction control sequencer
// Walks FETCH/DECODE/EXEC/MEM/WB/HALT per opcode class and emits Moore-decoded strobes.
module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic          stall,
  input  logic          resume,
  output logic [2:0]    stage,
  output logic          ir_write,
  output logic          pc_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          reg_write_en,
  output logic          push,
  output logic          pop,
  output logic          halted,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_FLOW, C_HALT, C_NOP} cls_t;

  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET  = 6'b000001;

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b011100, 6'b000101, 6'b001000,
      6'b001001, 6'b001100, 6'b001101:             classify = C_ALU;
      6'b100011:                                   classify = C_LOAD;
      6'b101011:                                   classify = C_STORE;
      6'b000010, 6'b000100, 6'b010001,
      6'b000011, 6'b000001:                        classify = C_FLOW;
      6'b111111:                                   classify = C_HALT;
      default:                                     classify = C_NOP;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic [5:0]    op_q, op_d;
  logic [CW-1:0] retired_q, retired_d;

  logic ir_s, pc_s, rd_s, wr_s, rw_s, push_s, pop_s;
  cls_t cls_q;
  logic last_mem;

  assign cls_q    = classify(op_q);
  assign last_mem = (wait_q == 3'(MEM_WAIT));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    retired_d = retired_q;
    ir_s      = 1'b0;
    pc_s      = 1'b0;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    rw_s      = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    // A stalled cycle leaves every register untouched and every strobe low.
    if (!stall) begin
      case (state_q)
        S_FETCH: begin
          ir_s    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          op_d    = opcode;
          state_d = (classify(opcode) == C_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          push_s = (op_q == OP_CALL);
          pop_s  = (op_q == OP_RET);
          case (cls_q)
            C_ALU:           state_d = S_WB;
            C_LOAD, C_STORE: begin
              state_d = S_MEM;
              wait_d  = 3'd0;
            end
            default: begin
              pc_s    = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          rd_s = (cls_q == C_LOAD);
          wr_s = (cls_q == C_STORE);
          if (last_mem) begin
            if (cls_q == C_STORE) begin
              pc_s    = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        S_WB: begin
          rw_s    = 1'b1;
          pc_s    = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT: begin
          if (resume) begin
            pc_s    = 1'b1;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
      if (pc_s) retired_d = retired_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 3'd0;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Gating with reset keeps strobes quiet the instant reset falls, not just after the flops clear.
  assign stage        = reset ? state_q : S_FETCH;
  assign halted       = reset & (state_q == S_HALT);
  assign ir_write     = reset & ir_s;
  assign pc_write     = reset & pc_s;
  assign mem_read     = reset & rd_s;
  assign mem_write    = reset & wr_s;
  assign reg_write_en = reset & rw_s;
  assign push         = reset & push_s;
  assign pop          = reset & pop_s;
  assign retired      = reset ? retired_q : '0;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed-vector bench for control_sequencer
// dut_a: MEM_WAIT=2, CW=4; dut_b: MEM_WAIT=3, CW=16; both share all inputs.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       stall = 1'b0;
  logic       resume = 1'b0;

  logic [2:0]  a_stage, b_stage;
  logic        a_ir, a_pc, a_rd, a_wr, a_rw, a_push, a_pop, a_halted;
  logic        b_ir, b_pc, b_rd, b_wr, b_rw, b_push, b_pop, b_halted;
  logic [3:0]  a_retired;
  logic [15:0] b_retired;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(2), .CW(4)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .resume(resume),
    .stage(a_stage), .ir_write(a_ir), .pc_write(a_pc), .mem_read(a_rd),
    .mem_write(a_wr), .reg_write_en(a_rw), .push(a_push), .pop(a_pop),
    .halted(a_halted), .retired(a_retired)
  );

  control_sequencer #(.MEM_WAIT(3), .CW(16)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .resume(resume),
    .stage(b_stage), .ir_write(b_ir), .pc_write(b_pc), .mem_read(b_rd),
    .mem_write(b_wr), .reg_write_en(b_rw), .push(b_push), .pop(b_pop),
    .halted(b_halted), .retired(b_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    stall  = 1'b0;
    resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stage", {29'd0, a_stage}, 32'd0);
    check("rst_retired", {28'd0, a_retired}, 32'd0);
    check("rst_strobes", {a_ir, a_pc, a_rd, a_wr, a_rw, a_push, a_pop, a_halted}, 32'd0);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_stage[7];
    int exp_rd[7];
    int exp_pc[7];

    // ADDI: 0,1,2,4,0
    opcode = 6'b001000;
    do_reset();
    check("addi_f_stage", {29'd0, a_stage}, 32'd0);
    check("addi_f_ir", {31'd0, a_ir}, 32'd1);
    tick(); #1;
    check("addi_d_stage", {29'd0, a_stage}, 32'd1);
    tick(); #1;
    check("addi_e_stage", {29'd0, a_stage}, 32'd2);
    check("addi_e_pc_rw", {30'd0, a_pc, a_rw}, 32'd0);
    tick(); #1;
    check("addi_wb_stage", {29'd0, a_stage}, 32'd4);
    check("addi_wb_pc_rw", {30'd0, a_pc, a_rw}, 32'd3);
    tick(); #1;
    check("addi_next_stage", {29'd0, a_stage}, 32'd0);
    check("addi_retired", {28'd0, a_retired}, 32'd1);

    // LW with MEM_WAIT=2 on dut_a
    opcode = 6'b100011;
    do_reset();
    exp_stage = '{0, 1, 2, 3, 3, 3, 4};
    exp_rd    = '{0, 0, 0, 1, 1, 1, 0};
    exp_pc    = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin tick(); #1; end
      check($sformatf("lw_stage%0d", i), {29'd0, a_stage}, 32'(exp_stage[i]));
      check($sformatf("lw_rd%0d", i), {31'd0, a_rd}, 32'(exp_rd[i]));
      check($sformatf("lw_pc%0d", i), {31'd0, a_pc}, 32'(exp_pc[i]));
    end
    tick(); #1;
    check("lw_next_stage", {29'd0, a_stage}, 32'd0);
    check("lw_retired", {28'd0, a_retired}, 32'd1);

    // CALL with 3 stall cycles on entering EXEC
    opcode = 6'b000011;
    do_reset();
    tick(); #1;
    tick(); stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick(); #1; end
      check($sformatf("call_stall_stage%0d", i), {29'd0, a_stage}, 32'd2);
      check($sformatf("call_stall_push_pc%0d", i), {30'd0, a_push, a_pc}, 32'd0);
    end
    tick(); stall = 1'b0; #1;
    check("call_stage", {29'd0, a_stage}, 32'd2);
    check("call_push_pc", {30'd0, a_push, a_pc}, 32'd3);
    check("call_retired_before", {28'd0, a_retired}, 32'd0);
    tick(); #1;
    check("call_next_stage", {29'd0, a_stage}, 32'd0);
    check("call_push_after", {31'd0, a_push}, 32'd0);
    check("call_retired", {28'd0, a_retired}, 32'd1);

    // RET: pop in EXEC only
    opcode = 6'b000001;
    do_reset();
    tick(); #1;
    tick(); #1;
    check("ret_exec", {27'd0, a_stage, a_pop, a_push}, {27'd0, 3'd2, 1'b1, 1'b0});
    tick(); #1;
    check("ret_next", {28'd0, a_stage, a_pop}, {28'd0, 3'd0, 1'b0});

    // NOP opcode: FETCH, DECODE, EXEC with pc_write in EXEC
    opcode = 6'b111000;
    do_reset();
    tick(); #1;
    tick(); #1;
    check("nop_exec", {28'd0, a_stage, a_pc}, {28'd0, 3'd2, 1'b1});
    tick(); #1;
    check("nop_next", {29'd0, a_stage}, 32'd0);

    // HALT, idle, stall-vs-resume, then resume
    opcode = 6'b111111;
    do_reset();
    tick(); #1;
    check("halt_decode", {29'd0, a_stage}, 32'd1);
    tick(); #1;
    check("halt_stage", {28'd0, a_stage, a_halted}, {28'd0, 3'd7, 1'b1});
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check($sformatf("halt_idle%0d", i), {27'd0, a_stage, a_pc, a_retired == 4'd0},
            {27'd0, 3'd7, 1'b0, 1'b1});
    end
    tick(); stall = 1'b1; resume = 1'b1; #1;
    check("halt_stall_wins_pc", {31'd0, a_pc}, 32'd0);
    tick(); stall = 1'b0; #1;
    check("halt_resume_pc", {28'd0, a_stage, a_pc}, {28'd0, 3'd7, 1'b1});
    tick(); resume = 1'b0; #1;
    check("halt_resume_next", {28'd0, a_stage, a_halted}, 32'd0);
    check("halt_retired", {28'd0, a_retired}, 32'd1);

    // SW on dut_b (MEM_WAIT=3), reset in 2nd MEM cycle
    opcode = 6'b101011;
    do_reset();
    tick(); #1;
    tick(); #1;
    tick(); #1;
    check("sw_mem1", {28'd0, b_stage, b_wr}, {28'd0, 3'd3, 1'b1});
    tick(); #1;
    check("sw_mem2", {28'd0, b_stage, b_wr}, {28'd0, 3'd3, 1'b1});
    reset = 1'b0; #1;
    check("sw_rst_stage", {29'd0, b_stage}, 32'd0);
    check("sw_rst_wr_pc", {30'd0, b_wr, b_pc}, 32'd0);
    check("sw_rst_retired", {16'd0, b_retired}, 32'd0);
    tick(); #1;
    check("sw_rst_hold", {28'd0, b_stage, b_pc}, 32'd0);

    // 16 back-to-back J on dut_a (CW=4): retired wraps 15 -> 0
    opcode = 6'b000010;
    do_reset();
    repeat (15 * 3) tick();
    #1;
    check("j_retired15", {28'd0, a_retired}, 32'd15);
    repeat (2) tick();
    #1;
    check("j_last_pc", {28'd0, a_stage, a_pc}, {28'd0, 3'd2, 1'b1});
    tick(); #1;
    check("j_retired_wrap", {28'd0, a_retired}, 32'd0);
    check("j_b_retired16", {16'd0, b_retired}, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
